// File: rtl/arb_grant_sequencer.sv
// Requester-side sequencer for a fixed-priority arbiter: registers client requests,
// locks ownership on a valid grant, and releases on done or hold timeout.
module arb_grant_sequencer #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    cli_req,
  input  logic [N-1:0]    cli_done,
  output logic [N-1:0]    cli_ack,
  output logic [N-1:0]    arb_req,
  input  logic [N-1:0]    arb_gnt,
  input  logic            arb_valid,
  output logic [ID_W-1:0] owner_id,
  output logic            busy,
  output logic            timeout_err,
  output logic            proto_err
);

  localparam int CW = $clog2(MAX_HOLD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]      r_state, w_nstate;
  logic [N-1:0]    r_pend, r_owner, r_ack, r_arb_req;
  logic [CW-1:0]   r_hold;
  logic [ID_W-1:0] r_id, w_gnt_id;
  logic            r_busy, r_to, r_pe;
  logic            w_onehot, w_gnt_ok, w_gnt_bad, w_done, w_tmo;

  // A grant is only accepted if it is one-hot and names a line we actually requested
  assign w_onehot  = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - N'(1))) == '0);
  assign w_gnt_ok  = arb_valid && w_onehot && ((arb_gnt & r_arb_req) != '0);
  assign w_gnt_bad = arb_valid && !w_gnt_ok;
  assign w_done    = (cli_done & r_owner) != '0;
  assign w_tmo     = !w_done && (r_hold == CW'(MAX_HOLD - 1));

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < N; i++)
      if (arb_gnt[i]) w_gnt_id = ID_W'(i);
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_ok) w_nstate = S_OWN;
      S_OWN:   if (w_done || w_tmo) w_nstate = S_REL;
      S_REL:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_owner   <= '0;
      r_hold    <= '0;
      r_ack     <= '0;
      r_arb_req <= '0;
      r_id      <= '0;
      r_busy    <= 1'b0;
      r_to      <= 1'b0;
      r_pe      <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_pend    <= cli_req;
      r_arb_req <= (w_nstate == S_IDLE) ? r_pend : '0;
      r_to      <= 1'b0;
      r_pe      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_ok) begin
            r_owner <= arb_gnt;
            r_hold  <= '0;
            r_ack   <= arb_gnt;
            r_id    <= w_gnt_id;
            r_busy  <= 1'b1;
          end else if (w_gnt_bad) begin
            r_pe <= 1'b1;
          end
        end
        S_OWN: begin
          if (w_done || w_tmo) begin
            r_ack  <= '0;
            r_busy <= 1'b0;
            r_to   <= w_tmo;
          end else begin
            r_hold <= r_hold + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cli_ack     = r_ack;
  assign arb_req     = r_arb_req;
  assign owner_id    = r_id;
  assign busy        = r_busy;
  assign timeout_err = r_to;
  assign proto_err   = r_pe;

endmodule

// File: tb/tb_arb_grant_sequencer.sv
// Scoreboard bench for arb_grant_sequencer with a behavioural fixed-priority arbiter.
module tb_arb_grant_sequencer;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  localparam int ID_W = 2;

  localparam int K_ACK = 0;
  localparam int K_END = 1;
  localparam int K_TO  = 2;
  localparam int K_PE  = 3;

  typedef struct {
    int kind;
    int id;
    int val;
    int num;
    bit chk_num;
  } ev_t;

  logic            clk, rst_n;
  logic [N-1:0]    cli_req, cli_done, cli_ack, arb_req, arb_gnt;
  logic            arb_valid, busy, timeout_err, proto_err;
  logic [ID_W-1:0] owner_id;

  logic            frc, frc_valid;
  logic [N-1:0]    frc_gnt;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;

  arb_grant_sequencer #(.N(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cli_req(cli_req), .cli_done(cli_done), .cli_ack(cli_ack), .arb_req(arb_req),
    .arb_gnt(arb_gnt), .arb_valid(arb_valid), .owner_id(owner_id), .busy(busy),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fixed-priority arbiter, LSB wins; frc lets the bench inject malformed grants
  always_comb begin
    arb_gnt   = '0;
    arb_valid = 1'b0;
    if (frc) begin
      arb_gnt   = frc_gnt;
      arb_valid = frc_valid;
    end else begin
      arb_valid = |arb_req;
      for (int i = 0; i < N; i++)
        if (arb_req[i] && arb_gnt == '0) arb_gnt[i] = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int id, input int val, input int num, input bit cn);
    ev_t e;
    e.kind = kind; e.id = id; e.val = val; e.num = num; e.chk_num = cn;
    q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int id, input int val, input int num);
    ev_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d val %0d, expected none (t=%0t)", kind, val, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == K_ACK && kind == K_ACK) begin
        chk("ack_value", val, e.val);
        chk("owner_id", id, e.id);
      end
      if (e.chk_num && kind == e.kind) chk(kind == K_END ? "ack_width" : "ack_gap", num, e.num);
    end
  endtask

  // Monitor: turns output activity into events and matches them against the queue
  initial begin : monitor
    logic [N-1:0] m_prev;
    int m_w, m_gap;
    m_prev = '0; m_w = 0; m_gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_prev = '0; m_w = 0; m_gap = 0;
      end else begin
        chk("ack_onehot0", int'($onehot0(cli_ack)), 1);
        chk("busy_vs_ack", int'(busy), int'(|cli_ack));
        if (m_prev != '0 && cli_ack == '0) sb_check(K_END, 0, 0, m_w);
        if (timeout_err) sb_check(K_TO, 0, 0, 0);
        if (proto_err)   sb_check(K_PE, 0, 0, 0);
        if (m_prev == '0 && cli_ack != '0) sb_check(K_ACK, int'(owner_id), int'(cli_ack), m_gap);
        if (cli_ack != '0) begin
          m_w   = (m_prev == '0) ? 1 : m_w + 1;
          m_gap = 0;
        end else begin
          m_gap++;
        end
        m_prev = cli_ack;
      end
    end
  end

  task automatic wait_ack(input logic [N-1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cli_ack != exp && n < 20);
    chk("wait_ack", int'(cli_ack), int'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cli_req = '0; cli_done = '0;
    frc = 1'b0; frc_valid = 1'b0; frc_gnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", int'(cli_ack), 0);
    chk("rst_arb_req", int'(arb_req), 0);
    chk("rst_owner_id", int'(owner_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_errs", int'({timeout_err, proto_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, latency
    cli_req = 4'b1000;
    push(K_ACK, 3, 4'b1000, 0, 0);
    @(negedge clk); chk("lat_arb_req_t", int'(arb_req), 0);
    @(negedge clk); chk("lat_arb_req_t1", int'(arb_req), 4'b1000);
                    chk("lat_ack_t1", int'(cli_ack), 0);
    @(negedge clk); chk("lat_ack_t2", int'(cli_ack), 4'b1000);
                    chk("lat_busy_t2", int'(busy), 1);
                    chk("lat_id_t2", int'(owner_id), 3);
    cli_done = 4'b1000; cli_req = '0;
    push(K_END, 0, 0, 1, 1);
    @(negedge clk); cli_done = '0;
    chk("rel_ack", int'(cli_ack), 0);
    chk("rel_owner_id_kept", int'(owner_id), 3);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_arb_req", int'(arb_req), 0);
    repeat (2) @(negedge clk);

    // Priority chain 1 -> 2 -> 3, each client drops req on done
    cli_req = 4'b1110;
    push(K_ACK, 1, 4'b0010, 0, 0);
    wait_ack(4'b0010);
    cli_done = 4'b0010; cli_req = 4'b1100;
    push(K_END, 0, 0, 1, 1);
    push(K_ACK, 2, 4'b0100, 2, 1);
    @(negedge clk); cli_done = '0;
    wait_ack(4'b0100);
    cli_done = 4'b0100; cli_req = 4'b1000;
    push(K_END, 0, 0, 1, 1);
    push(K_ACK, 3, 4'b1000, 2, 1);
    @(negedge clk); cli_done = '0;
    wait_ack(4'b1000);
    cli_done = 4'b1000; cli_req = '0;
    push(K_END, 0, 0, 1, 1);
    @(negedge clk); cli_done = '0;
    repeat (3) @(negedge clk);

    // Hold timeout, then re-grant of the still-requesting client
    cli_req = 4'b0001;
    push(K_ACK, 0, 4'b0001, 0, 0);
    push(K_END, 0, 0, MAX_HOLD, 1);
    push(K_TO, 0, 0, 0, 0);
    push(K_ACK, 0, 4'b0001, 2, 1);
    wait_ack(4'b0001);
    wait_ack(4'b0000);
    chk("timeout_pulse", int'(timeout_err), 1);
    @(negedge clk);
    chk("timeout_one_cycle", int'(timeout_err), 0);
    wait_ack(4'b0001);
    cli_done = 4'b0001; cli_req = '0;
    push(K_END, 0, 0, 1, 1);
    @(negedge clk); cli_done = '0;
    repeat (3) @(negedge clk);

    // Non-owner done ignored
    cli_req = 4'b0011;
    push(K_ACK, 0, 4'b0001, 0, 0);
    wait_ack(4'b0001);
    cli_done = 4'b0010;
    @(negedge clk);
    chk("nonowner_done_ack", int'(cli_ack), 4'b0001);
    cli_done = 4'b0011; cli_req = 4'b0010;
    push(K_END, 0, 0, 2, 1);
    push(K_ACK, 1, 4'b0010, 2, 1);
    @(negedge clk); cli_done = '0;
    wait_ack(4'b0010);
    cli_done = 4'b0010; cli_req = '0;
    push(K_END, 0, 0, 1, 1);
    @(negedge clk); cli_done = '0;
    repeat (3) @(negedge clk);

    // Malformed grants in IDLE
    frc = 1'b1; frc_valid = 1'b1; frc_gnt = 4'b0011;
    push(K_PE, 0, 0, 0, 0);
    @(negedge clk); chk("pe_multihot", int'(proto_err), 1);
    frc_gnt = 4'b0000;
    push(K_PE, 0, 0, 0, 0);
    @(negedge clk); chk("pe_zero", int'(proto_err), 1);
    frc_gnt = 4'b0001;
    push(K_PE, 0, 0, 0, 0);
    @(negedge clk); chk("pe_not_requested", int'(proto_err), 1);
    frc_valid = 1'b0; frc_gnt = 4'b0101;
    @(negedge clk); chk("pe_valid_low", int'(proto_err), 0);
    frc = 1'b0;
    @(negedge clk);
    chk("pe_ack_idle", int'(cli_ack), 0);
    chk("pe_busy_idle", int'(busy), 0);

    // Asynchronous reset mid-OWN
    cli_req = 4'b0100;
    push(K_ACK, 2, 4'b0100, 0, 0);
    wait_ack(4'b0100);
    @(negedge clk);
    #2 rst_n = 1'b0; cli_req = '0;
    #1;
    chk("arst_ack", int'(cli_ack), 0);
    chk("arst_arb_req", int'(arb_req), 0);
    chk("arst_owner_id", int'(owner_id), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_errs", int'({timeout_err, proto_err}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_arb_req", int'(arb_req), 0);
    chk("post_rst_ack", int'(cli_ack), 0);

    repeat (2) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_grant_sequencer.md
Name: arb_grant_sequencer

Overview:
- Requester-side companion to the 4-way combinational fixed-priority arbiter (LSB highest priority).
- Samples client request lines and drives them to the arbiter as `arb_req`.
- Consumes the arbiter's one-hot `gnt` and `valid`, then locks ownership of the shared resource for one client until that client signals done or a hold timeout expires.
- Provides registered, glitch-free per-client acknowledges and an owner ID.

Parameters:
- N, 4, number of clients; must equal the arbiter width.
- MAX_HOLD, 8, maximum OWN cycles before forced release (≥2).
- ID_W, 2, width of `owner_id`; equals clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cli_req  input  N  per-client request level; held by client until its ack is seen
- cli_done  input  N  per-client release strobe; only the owner's bit is honoured
- cli_ack  output  N  one-hot ownership acknowledge, registered
- arb_req  output  N  request vector to arbiter, registered
- arb_gnt  input  N  one-hot grant from arbiter (combinational from arb_req)
- arb_valid  input  1  arbiter valid (any request present)
- owner_id  output  ID_W  binary index of current owner; meaningful only while busy=1
- busy  output  1  high in OWN
- timeout_err  output  1  one-cycle pulse on forced release
- proto_err  output  1  one-cycle pulse on malformed grant

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately mid-operation:
  - state=IDLE, pend_q=0, owner_q=0, hold_cnt=0.
  - cli_ack=0, arb_req=0, owner_id=0, busy=0, timeout_err=0, proto_err=0.
- pend_q <= cli_req every cycle in every state.
- arb_req is registered:
  - arb_req <= pend_q when next state is IDLE.
  - arb_req <= 0 otherwise.
- States are IDLE, OWN and RELEASE.
- IDLE:
  - If arb_valid=1, arb_gnt is exactly one-hot, and (arb_gnt & arb_req)≠0:
    - owner_q <= arb_gnt, hold_cnt <= 0.
    - cli_ack <= arb_gnt, owner_id <= encode(arb_gnt), busy <= 1.
    - go to OWN.
  - Else if arb_valid=1 and the grant is zero, multi-hot, or not in arb_req:
    - proto_err pulses one cycle; stay in IDLE.
  - arb_valid=0: stay in IDLE, no error.
- Latency:
  - cli_req high before edge t → pend_q at t.
  - arb_req at t+1.
  - cli_ack/busy high at t+2.
- OWN:
  - cli_ack=owner_q, held stable.
  - hold_cnt increments each cycle.
  - If cli_done & owner_q ≠ 0 → RELEASE.
  - Else if hold_cnt = MAX_HOLD-1 → RELEASE and timeout_err pulses in the same transition cycle.
  - If done and timeout coincide, done wins; no timeout_err.
  - cli_done from non-owners is ignored; no effect.
  - Changes on arb_gnt/arb_valid are ignored; arb_req=0 here, so valid is expected low.
- RELEASE:
  - Exactly one cycle.
  - cli_ack=0, busy=0, arb_req=0; owner_id retains last value.
  - Next state is IDLE, with arb_req reloaded from pend_q.
- Re-grant after release:
  - If the released client still holds cli_req, it is eligible again.
  - Fixed priority then re-grants it over higher-index clients; this is intended, and clients must drop req on done.
- Maximum ack width is MAX_HOLD cycles.
- Minimum gap between consecutive acks is 2 cycles (RELEASE + IDLE).
- cli_ack is never multi-hot.

Test Plan:
- Single request: rst_n released, cli_req=1000.
  - arb_req=1000 at t+1; cli_ack=1000, owner_id=3, busy=1 at t+2.
  - cli_done=1000 for one cycle → cli_ack=0 next cycle, IDLE one cycle later.
- Priority: cli_req=1110 held.
  - Ack 0010, owner_id=1.
  - On done, client 1 drops req; after the 2-cycle gap, ack 0100, owner_id=2.
- Timeout: cli_req=0001, never done, MAX_HOLD=8.
  - cli_ack=0001 for exactly 8 cycles.
  - timeout_err pulses once on the release cycle; ack returns 2 cycles later if req still held.
- Non-owner done / ack stability: owner=0001, cli_req=0011.
  - cli_done=0010 causes no change; cli_ack stays 0001.
  - cli_done=0011 → release.
- Malformed grant: force arb_valid=1, arb_gnt=0011 in IDLE → proto_err pulse, cli_ack stays 0000.
  - arb_valid=1, arb_gnt=0000 → proto_err.
- Reset mid-OWN: rst_n low asynchronously between edges while cli_ack=0100.
  - All outputs 0 immediately.
  - After rst_n high with cli_req=0000, state stays IDLE.
  - No error pulses.
